// File: rtl/morph_filter.sv
// 3x3 binary erosion/dilation over a raster-fetched binarized map.
// Two line buffers feed a sliding window; edge neighbours are masked by coordinate.
module morph_filter #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  parameter int ADDR_W = 16
) (
  input  logic              morph_clk,
  input  logic              morph_rst_n,
  input  logic              morph_ctrl,
  input  logic              mode,
  output logic [ADDR_W-1:0] pixel_address,
  input  logic              bin_data,
  output logic              out_valid,
  output logic              out_data,
  output logic [ADDR_W-1:0] out_address,
  output logic              busy,
  output logic              done,
  output logic [1:0]        condition_led
);
  localparam int CW = ADDR_W + 1;
  localparam int LW = $clog2(WIDTH);
  localparam logic [CW-1:0]     K_FETCH_END = CW'(WIDTH*HEIGHT - 1);
  localparam logic [CW-1:0]     K_FLUSH_END = CW'(WIDTH*HEIGHT + WIDTH);
  localparam logic [CW-1:0]     K_OUT_START = CW'(WIDTH + 1);
  localparam logic [CW-1:0]     P_ROW1      = CW'(WIDTH);
  localparam logic [CW-1:0]     P_LAST_ROW  = CW'((HEIGHT-1)*WIDTH);
  localparam logic [CW-1:0]     K_ONE       = CW'(1);
  localparam logic [ADDR_W-1:0] A_ONE       = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FLUSH, S_DONE} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_k;
  logic              r_mode, r_busy, r_done, r_sticky;
  logic [WIDTH-1:0]  r_lb0, r_lb1;
  logic [2:0]        r_c1, r_c2;  // window columns x and x-1, {top, mid, bot}
  logic              r_out_valid, r_out_data;
  logic [ADDR_W-1:0] r_out_addr, r_pix_addr;

  logic          w_px, w_lb0, w_lb1, w_res;
  logic          w_top_ok, w_bot_ok, w_lft_ok, w_rgt_ok;
  logic [LW-1:0] w_col, w_x;
  logic [CW-1:0] w_p;
  logic [2:0]    w_c0, w_rmask;
  logic [8:0]    w_win, w_mask;

  // Newest column is combinational: pixel k with the two pixels one and two rows above.
  assign w_px  = (r_state == S_FETCH) & bin_data;
  assign w_col = r_k[LW-1:0];
  assign w_lb1 = r_lb1[w_col];
  assign w_lb0 = r_lb0[w_col];
  assign w_c0  = {w_lb0, w_lb1, w_px};

  // Window centre sits WIDTH+1 pixels behind the fetch point.
  assign w_p      = r_k - K_OUT_START;
  assign w_x      = w_p[LW-1:0];
  assign w_top_ok = (w_p >= P_ROW1);
  assign w_bot_ok = (w_p < P_LAST_ROW);
  assign w_lft_ok = (w_x != '0);
  assign w_rgt_ok = (w_x != '1);
  assign w_rmask  = {w_top_ok, 1'b1, w_bot_ok};
  assign w_win    = {r_c2, r_c1, w_c0};
  assign w_mask   = {w_rmask & {3{w_lft_ok}}, w_rmask, w_rmask & {3{w_rgt_ok}}};
  assign w_res    = r_mode ? |(w_win & w_mask) : &(w_win | ~w_mask);

  always_ff @(posedge morph_clk or negedge morph_rst_n) begin
    if (!morph_rst_n) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_mode      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sticky    <= 1'b0;
      r_lb0       <= '0;
      r_lb1       <= '0;
      r_c1        <= '0;
      r_c2        <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= 1'b0;
      r_out_addr  <= '0;
      r_pix_addr  <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (morph_ctrl) begin
            r_mode     <= mode;
            r_k        <= '0;
            r_sticky   <= 1'b0;
            r_pix_addr <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH, S_FLUSH: begin
          r_lb1[w_col] <= w_px;
          r_lb0[w_col] <= w_lb1;
          r_c2         <= r_c1;
          r_c1         <= w_c0;
          r_k          <= r_k + K_ONE;
          if (r_k >= K_OUT_START) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_res;
            r_out_addr  <= w_p[ADDR_W-1:0];
          end
          if (r_state == S_FETCH) begin
            if (r_k == K_FETCH_END) begin
              r_pix_addr <= '0;
              r_state    <= S_FLUSH;
            end else begin
              r_pix_addr <= r_k[ADDR_W-1:0] + A_ONE;
            end
          end else if (r_k == K_FLUSH_END) begin
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done   <= 1'b1;
          r_sticky <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pixel_address = r_pix_addr;
  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign out_address   = r_out_addr;
  assign busy          = r_busy;
  assign done          = r_done;
  assign condition_led = {r_sticky, r_busy};

endmodule
